// File: rtl/cluster_count_sequencer.sv
// -----------------------------------------------------------------------------
// cluster_count_sequencer
//
// Issues latch pulses to an external cluster-counting pipeline, tracks each
// request through a fixed-latency tag pipe, and captures the returned count
// and overflow flag when the tag emerges. It also keeps running statistics
// and a hysteretic throttle indication driven by overflow runs.
//
// Ports
//   clock           in   sole clock, rising edge
//   reset_n         in   asynchronous active-low reset (release synchronised)
//   enable_i        in   sampling permitted when high
//   strobe_i        in   single-cycle sample request
//   clear_i         in   synchronous clear of max / sample / overflow stats
//   cnt_i           in   count returned by the pipeline (CNT_WIDTH)
//   overflow_i      in   overflow flag aligned with cnt_i
//   latch_o         out  registered latch pulse to the pipeline
//   valid_o         out  one-cycle pulse: cnt_o / ovf_o are fresh
//   cnt_o, ovf_o    out  last captured sample
//   max_cnt_o       out  largest captured count since reset/clear
//   ovf_total_o     out  saturating count of overflow samples
//   sample_total_o  out  saturating count of samples
//   throttle_o      out  high while the throttle FSM is in THROTTLE
// -----------------------------------------------------------------------------
module cluster_count_sequencer #(
    parameter int LATENCY    = 9,
    parameter int CNT_WIDTH  = 11,
    parameter int ENTER_N    = 4,
    parameter int EXIT_N     = 8,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic                  strobe_i,
    input  logic                  clear_i,
    input  logic [CNT_WIDTH-1:0]  cnt_i,
    input  logic                  overflow_i,
    output logic                  latch_o,
    output logic                  valid_o,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic                  ovf_o,
    output logic [CNT_WIDTH-1:0]  max_cnt_o,
    output logic [STAT_WIDTH-1:0] ovf_total_o,
    output logic [STAT_WIDTH-1:0] sample_total_o,
    output logic                  throttle_o
);

    localparam int RUN_MAX = (ENTER_N > EXIT_N) ? ENTER_N : EXIT_N;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [STAT_WIDTH-1:0] STAT_ALL_ONES = {STAT_WIDTH{1'b1}};

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_THROTTLE = 1'b1
    } state_t;

    logic [1:0]            rst_sync_q;
    logic                  latch_q;
    logic [LATENCY-1:0]    tag_q;
    logic                  capture;
    logic                  valid_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  ovf_q;
    logic [CNT_WIDTH-1:0]  max_q, max_d;
    logic [STAT_WIDTH-1:0] ovf_tot_q, ovf_tot_d;
    logic [STAT_WIDTH-1:0] smp_tot_q, smp_tot_d;
    state_t                state_q, state_d;
    logic [RUN_W-1:0]      run_q, run_d;

    // Two-stage release synchroniser: new latches are only issued once the
    // deasserted reset has propagated through both stages.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            latch_q <= 1'b0;
        end else begin
            latch_q <= strobe_i & enable_i & rst_sync_q[1];
        end
    end

    // Tag pipe: one bit per stage, so every cycle can carry its own request
    // and back-to-back strobes come out back-to-back.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_q[0] <= 1'b0;
        end else begin
            tag_q[0] <= latch_q;
        end
    end

    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    tag_q[gi] <= 1'b0;
                end else begin
                    tag_q[gi] <= tag_q[gi-1];
                end
            end
        end
    endgenerate

    // The pipeline's data is valid exactly while the oldest tag is present.
    assign capture = tag_q[LATENCY-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= capture;
            if (capture) begin
                cnt_q <= cnt_i;
                ovf_q <= overflow_i;
            end
        end
    end

    // Statistics are folded in on the capture edge so they are current in the
    // same cycle valid_o is high. A coincident clear discards the sample.
    always_comb begin
        max_d     = max_q;
        ovf_tot_d = ovf_tot_q;
        smp_tot_d = smp_tot_q;
        if (clear_i) begin
            max_d     = '0;
            ovf_tot_d = '0;
            smp_tot_d = '0;
        end else if (capture) begin
            if (cnt_i > max_q) begin
                max_d = cnt_i;
            end
            if (smp_tot_q != STAT_ALL_ONES) begin
                smp_tot_d = smp_tot_q + 1'b1;
            end
            if (overflow_i && (ovf_tot_q != STAT_ALL_ONES)) begin
                ovf_tot_d = ovf_tot_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            max_q     <= '0;
            ovf_tot_q <= '0;
            smp_tot_q <= '0;
        end else begin
            max_q     <= max_d;
            ovf_tot_q <= ovf_tot_d;
            smp_tot_q <= smp_tot_d;
        end
    end

    // Throttle FSM: the run counter only moves on captured samples and is
    // zeroed on the transition, so it never exceeds max(ENTER_N, EXIT_N)-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_NORMAL;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (capture) begin
            case (state_q)
                ST_NORMAL: begin
                    if (!overflow_i) begin
                        run_d = '0;
                    end else if (run_q == RUN_W'(ENTER_N - 1)) begin
                        state_d = ST_THROTTLE;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                default: begin
                    if (overflow_i) begin
                        run_d = '0;
                    end else if (run_q == RUN_W'(EXIT_N - 1)) begin
                        state_d = ST_NORMAL;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign latch_o        = latch_q;
    assign valid_o        = valid_q;
    assign cnt_o          = cnt_q;
    assign ovf_o          = ovf_q;
    assign max_cnt_o      = max_q;
    assign ovf_total_o    = ovf_tot_q;
    assign sample_total_o = smp_tot_q;
    assign throttle_o     = (state_q == ST_THROTTLE);

endmodule

// File: tb/tb_cluster_count_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cluster_count_sequencer
//
// Directed scenarios followed by a randomized run. The bench plays the role of
// the external counting pipeline: for every accepted strobe it schedules the
// returned count/overflow to be presented LATENCY clocks after the latch
// sample edge, and it predicts when valid_o must pulse, what is captured, the
// statistics and the throttle state from the behavioural rules.
// -----------------------------------------------------------------------------
module tb_cluster_count_sequencer;

    localparam int L       = 9;
    localparam int CW      = 11;
    localparam int SW      = 4;
    localparam int ENTER_N = 4;
    localparam int EXIT_N  = 8;
    localparam int NMAX    = 2048;
    localparam int SATV    = (1 << SW) - 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable_i = 1'b0;
    logic          strobe_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [CW-1:0] cnt_i = '0;
    logic          overflow_i = 1'b0;
    logic          latch_o;
    logic          valid_o;
    logic [CW-1:0] cnt_o;
    logic          ovf_o;
    logic [CW-1:0] max_cnt_o;
    logic [SW-1:0] ovf_total_o;
    logic [SW-1:0] sample_total_o;
    logic          throttle_o;

    always #5 clock = ~clock;

    cluster_count_sequencer #(
        .LATENCY(L), .CNT_WIDTH(CW), .ENTER_N(ENTER_N), .EXIT_N(EXIT_N), .STAT_WIDTH(SW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable_i(enable_i), .strobe_i(strobe_i),
        .clear_i(clear_i), .cnt_i(cnt_i), .overflow_i(overflow_i), .latch_o(latch_o),
        .valid_o(valid_o), .cnt_o(cnt_o), .ovf_o(ovf_o), .max_cnt_o(max_cnt_o),
        .ovf_total_o(ovf_total_o), .sample_total_o(sample_total_o), .throttle_o(throttle_o)
    );

    // Schedule of returned samples, indexed by the clock edge at which the
    // pipeline must present them (and at which the DUT must capture them).
    bit  has_s[NMAX];
    int  ret_c[NMAX];
    bit  ret_o[NMAX];

    int  n = 0;
    int  total = 0;
    int  fails = 0;
    int  m_cnt, m_max, m_tot, m_otot, m_run;
    bit  m_ovf, m_thr, m_latch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < SATV) ? v + 1 : v;
    endfunction

    task automatic model_clear_all();
        for (int i = 0; i < NMAX; i++) has_s[i] = 1'b0;
        m_cnt = 0; m_ovf = 0; m_max = 0; m_tot = 0; m_otot = 0;
        m_run = 0; m_thr = 0; m_latch = 0;
    endtask

    // One clock: drive inputs for the next edge, advance, update the model,
    // compare all outputs and print one line per captured sample.
    task automatic step(input bit stb, input bit en, input bit clr, input int c, input bit o);
        strobe_i = stb;
        enable_i = en;
        clear_i  = clr;
        if (stb && en) begin
            has_s[n + 2 + L] = 1'b1;
            ret_c[n + 2 + L] = c;
            ret_o[n + 2 + L] = o;
        end
        if (has_s[n + 1]) begin
            cnt_i      = CW'(ret_c[n + 1]);
            overflow_i = ret_o[n + 1];
        end else begin
            cnt_i      = CW'($urandom_range(0, (1 << CW) - 1));
            overflow_i = 1'($urandom_range(0, 1));
        end
        @(posedge clock);
        n++;
        #1;
        m_latch = stb && en;
        if (clr) begin
            m_max = 0; m_tot = 0; m_otot = 0;
        end
        if (has_s[n]) begin
            m_cnt = ret_c[n];
            m_ovf = ret_o[n];
            if (!clr) begin
                if (m_cnt > m_max) m_max = m_cnt;
                m_tot = sat_inc(m_tot);
                if (m_ovf) m_otot = sat_inc(m_otot);
            end
            if (!m_thr) begin
                m_run = m_ovf ? m_run + 1 : 0;
                if (m_run == ENTER_N) begin m_thr = 1; m_run = 0; end
            end else begin
                m_run = m_ovf ? 0 : m_run + 1;
                if (m_run == EXIT_N) begin m_thr = 0; m_run = 0; end
            end
            $display("sample edge=%0d cnt=%0d ovf=%0d max=%0d tot=%0d otot=%0d thr=%0d",
                     n, cnt_o, ovf_o, max_cnt_o, sample_total_o, ovf_total_o, throttle_o);
        end
        chk("latch", 32'(latch_o), 32'(m_latch));
        chk("valid", 32'(valid_o), 32'(has_s[n]));
        chk("cnt", 32'(cnt_o), 32'(m_cnt));
        chk("ovf", 32'(ovf_o), 32'(m_ovf));
        chk("max", 32'(max_cnt_o), 32'(m_max));
        chk("sample_total", 32'(sample_total_o), 32'(m_tot));
        chk("ovf_total", 32'(ovf_total_o), 32'(m_otot));
        chk("throttle", 32'(throttle_o), 32'(m_thr));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any edge.
    task automatic do_reset();
        #2;
        reset_n  = 1'b0;
        strobe_i = 1'b0;
        clear_i  = 1'b0;
        #1;
        chk("rst_latch", 32'(latch_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_cnt", 32'(cnt_o), 0);
        chk("rst_ovf", 32'(ovf_o), 0);
        chk("rst_max", 32'(max_cnt_o), 0);
        chk("rst_ovf_total", 32'(ovf_total_o), 0);
        chk("rst_sample_total", 32'(sample_total_o), 0);
        chk("rst_throttle", 32'(throttle_o), 0);
        model_clear_all();
        repeat (2) begin
            @(posedge clock);
            n++;
        end
        #3;
        reset_n = 1'b1;
        $display("reset released at edge=%0d", n);
        idle(3);
    endtask

    bit pat32[24] = '{1,1,1,0,1,1,1,1, 0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0};

    initial begin
        model_clear_all();
        do_reset();

        // Single strobe returning 37.
        step(1'b1, 1'b1, 1'b0, 37, 1'b0);
        idle(L + 2);
        chk("single_cnt", 32'(cnt_o), 37);
        chk("single_max", 32'(max_cnt_o), 37);
        chk("single_total", 32'(sample_total_o), 1);

        // Back-to-back strobes, ramp 0..19; totals saturate at 15 for SW=4.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, i, 1'b0);
        idle(L + 2);
        chk("ramp_last_cnt", 32'(cnt_o), 19);
        chk("ramp_max", 32'(max_cnt_o), 37);
        step(1'b0, 1'b1, 1'b1, 0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, i, 1'b0);
        idle(L + 2);
        chk("ramp2_max", 32'(max_cnt_o), 19);
        chk("ramp2_total_sat", 32'(sample_total_o), 15);

        // Throttle entry/exit pattern.
        step(1'b0, 1'b1, 1'b1, 0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, int'($urandom_range(0, 2047)), pat32[i]);
        idle(L + 2);
        chk("thr_entered", 32'(throttle_o), 1);
        for (int i = 8; i < 23; i++) step(1'b1, 1'b1, 1'b0, int'($urandom_range(0, 2047)), pat32[i]);
        idle(L + 2);
        chk("thr_held", 32'(throttle_o), 1);
        step(1'b1, 1'b1, 1'b0, 5, pat32[23]);
        idle(L + 2);
        chk("thr_exited", 32'(throttle_o), 0);

        // Saturation of both counters with 20 overflow samples.
        step(1'b0, 1'b1, 1'b1, 0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 100 + i, 1'b1);
        idle(L + 2);
        chk("sat_ovf_total", 32'(ovf_total_o), 15);
        chk("sat_sample_total", 32'(sample_total_o), 15);

        // Enable low: strobes ignored, nothing comes back.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 7, 1'b0);
        idle(L + 2);

        // Clear coincident with the capture of cnt=500.
        step(1'b1, 1'b1, 1'b0, 500, 1'b0);
        idle(L);
        step(1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("clr_valid", 32'(valid_o), 1);
        chk("clr_cnt", 32'(cnt_o), 500);
        chk("clr_max", 32'(max_cnt_o), 0);
        chk("clr_total", 32'(sample_total_o), 0);
        chk("clr_ovf_total", 32'(ovf_total_o), 0);

        // Reset three cycles after a strobe: the sample must never appear.
        step(1'b1, 1'b1, 1'b0, 123, 1'b0);
        idle(3);
        do_reset();
        idle(L + 4);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 40) == 0), int'($urandom_range(0, (1 << CW) - 1)),
                 1'($urandom_range(0, 2) == 0));
        end
        idle(L + 3);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/cluster_count_sequencer.md
CLUSTER_COUNT_SEQUENCER -- requirements
Module: cluster_count_sequencer

Interface
REQ-001 Parameters: LATENCY, default 9, clocks from latch_o sample edge to valid cnt_i/overflow_i; CNT_WIDTH, default 11, count width; ENTER_N, default 4, consecutive overflows to enter throttle; EXIT_N, default 8, consecutive clean samples to exit throttle; STAT_WIDTH, default 16, statistics counter width.
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 enable_i  in  1  sampling permitted when high.
REQ-005 strobe_i  in  1  single-cycle sample request (one per bunch crossing).
REQ-006 clear_i  in  1  synchronous clear of statistics (max, counters).
REQ-007 cnt_i  in  CNT_WIDTH  cluster count returned by counting pipeline.
REQ-008 overflow_i  in  1  overflow flag aligned with cnt_i.
REQ-009 latch_o  out  1  registered latch pulse to counting pipeline.
REQ-010 valid_o  out  1  one-cycle pulse: cnt_o/ovf_o hold a fresh sample.
REQ-011 cnt_o  out  CNT_WIDTH  captured count; ovf_o  out  1  captured overflow.
REQ-012 max_cnt_o  out  CNT_WIDTH  largest captured count since reset/clear.
REQ-013 ovf_total_o  out  STAT_WIDTH  saturating count of overflow samples; sample_total_o  out  STAT_WIDTH  saturating count of samples.
REQ-014 throttle_o  out  1  high while throttle state machine is in THROTTLE.

Function
REQ-015 latch_o SHALL be asserted the cycle after strobe_i=1 with enable_i=1, and SHALL otherwise be 0; it is a registered, single-cycle pulse.
REQ-016 Each latch_o pulse SHALL enter a LATENCY-deep tag shift register; a tag exiting it SHALL capture cnt_i/overflow_i into cnt_o/ovf_o and pulse valid_o on the following cycle.
REQ-017 Pipeline is fully pipelined: back-to-back strobes (every cycle) SHALL produce back-to-back valid_o pulses, none lost, in order.
REQ-018 Deasserting enable_i SHALL stop new latches only; samples already in flight SHALL still complete.
REQ-019 cnt_o/ovf_o SHALL hold their last value between valid_o pulses.
REQ-020 On valid_o: max_cnt_o <= max(max_cnt_o, cnt_o-sample); sample_total_o +1; ovf_total_o +1 if sample overflowed; both counters SHALL saturate at all-ones, never wrap.
REQ-021 clear_i SHALL zero max_cnt_o, ovf_total_o, sample_total_o next cycle; if a capture coincides, clear wins and that sample is not accumulated; in-flight tags, cnt_o, throttle state unaffected.
REQ-022 Throttle FSM states NORMAL (throttle_o=0) and THROTTLE (throttle_o=1); a run counter advances only on captured samples.
REQ-023 NORMAL: overflow sample increments run, clean sample zeroes it; run reaching ENTER_N SHALL transition to THROTTLE and zero run in the same cycle.
REQ-024 THROTTLE: clean sample increments run, overflow sample zeroes it; run reaching EXIT_N SHALL transition to NORMAL and zero run.
REQ-025 throttle_o SHALL change in the same cycle valid_o pulses for the triggering sample.
REQ-026 Run counter SHALL be wide enough for max(ENTER_N,EXIT_N) and never wrap.

Reset
REQ-027 reset_n low SHALL asynchronously force: latch_o=0, valid_o=0, tag register empty, cnt_o=0, ovf_o=0, max_cnt_o=0, ovf_total_o=0, sample_total_o=0, run=0, FSM=NORMAL, throttle_o=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight samples; no valid_o SHALL appear for strobes issued before reset release.
REQ-029 Release of reset_n SHALL be synchronised internally; first strobe accepted on the second clock after release.

Verification
REQ-030 Single strobe, enable=1, cnt_i=37 at return -> latch_o at t+1, valid_o at t+1+LATENCY+1, cnt_o=37, sample_total_o=1, max_cnt_o=37.
REQ-031 Strobe every cycle for 20 cycles, cnt_i ramps 0..19 -> 20 consecutive valid_o, cnt_o 0..19 in order, max_cnt_o=19.
REQ-032 ENTER_N=4: overflow samples O,O,O,clean,O,O,O,O -> throttle_o rises only on 8th valid_o; then 7 clean, 1 overflow, 8 clean -> throttle_o falls on last valid_o.
REQ-033 STAT_WIDTH=4, 20 overflow samples -> ovf_total_o and sample_total_o stick at 15.
REQ-034 clear_i coincident with valid_o carrying cnt=500 -> max_cnt_o=0, counters 0, cnt_o=500.
REQ-035 reset_n pulsed low 3 cycles after a strobe -> no valid_o for that strobe; all outputs at reset values.
